// File: rtl/frame_slot_sched.sv
// Frame-slot scheduler for a multi-buffer frame store.
// Hands the write DMA and the read controller slot base addresses so that
// the writer never lands on the slot being displayed or on the newest
// completed-but-unread frame.
module frame_slot_sched #(
   parameter int unsigned START_ADDR      = 0,
   parameter int unsigned FRAMES_AMOUNT   = 3,
   parameter int unsigned BYTES_PER_FRAME = 4147200,
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned CNT_WIDTH       = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  wr_start_stb_i,
   input  logic                  wr_done_stb_i,
   output logic [ADDR_WIDTH-1:0] wr_addr_o,
   output logic                  wr_active_o,
   input  logic                  rd_next_stb_i,
   output logic [ADDR_WIDTH-1:0] rd_addr_o,
   output logic                  rd_frame_valid_o,
   output logic                  rd_new_frame_o,
   output logic                  rd_repeat_o,
   output logic [CNT_WIDTH-1:0]  dropped_cnt_o,
   output logic [CNT_WIDTH-1:0]  repeat_cnt_o
);

   localparam int unsigned SLOT_W = (FRAMES_AMOUNT > 1) ? $clog2(FRAMES_AMOUNT) : 1;

   // Fewer than three slots cannot keep reader, newest and writer apart.
   generate
      if (FRAMES_AMOUNT < 3) begin : g_bad_frames
         $error("frame_slot_sched: FRAMES_AMOUNT must be >= 3");
      end
   endgenerate

   // Base address of a slot, wrapped to the address width.
   function automatic logic [ADDR_WIDTH-1:0] slot_base(input logic [SLOT_W-1:0] slot);
      return ADDR_WIDTH'(START_ADDR) + ADDR_WIDTH'(BYTES_PER_FRAME) * ADDR_WIDTH'(slot);
   endfunction

   logic [SLOT_W-1:0]     r_wr_slot;
   logic [SLOT_W-1:0]     r_rd_slot;
   logic [SLOT_W-1:0]     r_newest_slot;
   logic                  r_newest_valid;
   logic                  r_wr_active;
   logic                  r_rd_valid;
   logic [ADDR_WIDTH-1:0] r_wr_addr;
   logic [ADDR_WIDTH-1:0] r_rd_addr;
   logic                  r_rd_new;
   logic                  r_rd_repeat;
   logic [CNT_WIDTH-1:0]  r_drop_cnt;
   logic [CNT_WIDTH-1:0]  r_rep_cnt;

   logic [SLOT_W-1:0]     w_wr_slot_next;
   logic [SLOT_W-1:0]     w_rd_slot_next;
   logic [SLOT_W-1:0]     w_newest_slot_next;
   logic                  w_newest_valid_next;
   logic                  w_wr_active_next;
   logic                  w_rd_valid_next;
   logic [ADDR_WIDTH-1:0] w_wr_addr_next;
   logic [ADDR_WIDTH-1:0] w_rd_addr_next;
   logic                  w_rd_new_next;
   logic                  w_rd_repeat_next;
   logic [CNT_WIDTH-1:0]  w_drop_cnt_next;
   logic [CNT_WIDTH-1:0]  w_rep_cnt_next;
   logic [SLOT_W-1:0]     w_sel;

   // Resolve done, then read, then write, each stage seeing the previous stage's result.
   always_comb begin
      w_wr_slot_next      = r_wr_slot;
      w_rd_slot_next      = r_rd_slot;
      w_newest_slot_next  = r_newest_slot;
      w_newest_valid_next = r_newest_valid;
      w_wr_active_next    = r_wr_active;
      w_rd_valid_next     = r_rd_valid;
      w_wr_addr_next      = r_wr_addr;
      w_rd_addr_next      = r_rd_addr;
      w_rd_new_next       = 1'b0;
      w_rd_repeat_next    = 1'b0;
      w_drop_cnt_next     = r_drop_cnt;
      w_rep_cnt_next      = r_rep_cnt;
      w_sel               = '0;

      // Publish the finished frame; an unread newest frame gets overwritten.
      if (wr_done_stb_i && r_wr_active) begin
         if (r_newest_valid && (r_newest_slot != r_rd_slot) && (r_drop_cnt != '1)) begin
            w_drop_cnt_next = r_drop_cnt + CNT_WIDTH'(1);
         end
         w_newest_slot_next  = r_wr_slot;
         w_newest_valid_next = 1'b1;
         w_wr_active_next    = 1'b0;
      end

      // Reader takes the newest frame if one is waiting, else repeats.
      if (rd_next_stb_i) begin
         if (w_newest_valid_next) begin
            w_rd_slot_next      = w_newest_slot_next;
            w_rd_addr_next      = slot_base(w_newest_slot_next);
            w_newest_valid_next = 1'b0;
            w_rd_valid_next     = 1'b1;
            w_rd_new_next       = 1'b1;
         end else begin
            w_rd_repeat_next = 1'b1;
            if (r_rep_cnt != '1) begin
               w_rep_cnt_next = r_rep_cnt + CNT_WIDTH'(1);
            end
         end
      end

      // Lowest slot not held by the reader nor by the newest frame.
      for (int i = FRAMES_AMOUNT - 1; i >= 0; i--) begin
         if (!(w_rd_valid_next && (SLOT_W'(i) == w_rd_slot_next)) &&
             !(w_newest_valid_next && (SLOT_W'(i) == w_newest_slot_next))) begin
            w_sel = SLOT_W'(i);
         end
      end

      if (wr_start_stb_i) begin
         w_wr_slot_next   = w_sel;
         w_wr_addr_next   = slot_base(w_sel);
         w_wr_active_next = 1'b1;
      end
   end

   // State register; reset clears everything, forgetting in-flight frames.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_wr_slot      <= '0;
         r_rd_slot      <= '0;
         r_newest_slot  <= '0;
         r_newest_valid <= 1'b0;
         r_wr_active    <= 1'b0;
         r_rd_valid     <= 1'b0;
         r_wr_addr      <= ADDR_WIDTH'(START_ADDR);
         r_rd_addr      <= ADDR_WIDTH'(START_ADDR);
         r_rd_new       <= 1'b0;
         r_rd_repeat    <= 1'b0;
         r_drop_cnt     <= '0;
         r_rep_cnt      <= '0;
      end else begin
         r_wr_slot      <= w_wr_slot_next;
         r_rd_slot      <= w_rd_slot_next;
         r_newest_slot  <= w_newest_slot_next;
         r_newest_valid <= w_newest_valid_next;
         r_wr_active    <= w_wr_active_next;
         r_rd_valid     <= w_rd_valid_next;
         r_wr_addr      <= w_wr_addr_next;
         r_rd_addr      <= w_rd_addr_next;
         r_rd_new       <= w_rd_new_next;
         r_rd_repeat    <= w_rd_repeat_next;
         r_drop_cnt     <= w_drop_cnt_next;
         r_rep_cnt      <= w_rep_cnt_next;
      end
   end

   assign wr_addr_o        = r_wr_addr;
   assign wr_active_o      = r_wr_active;
   assign rd_addr_o        = r_rd_addr;
   assign rd_frame_valid_o = r_rd_valid;
   assign rd_new_frame_o   = r_rd_new;
   assign rd_repeat_o      = r_rd_repeat;
   assign dropped_cnt_o    = r_drop_cnt;
   assign repeat_cnt_o     = r_rep_cnt;

endmodule

// File: tb/tb_frame_slot_sched.sv
// Directed bench for frame_slot_sched: a table of strobe patterns with
// hand-computed outputs, then an asynchronous reset sequence.
module tb_frame_slot_sched;

   localparam logic [31:0] S0 = 32'h0000_0000;
   localparam logic [31:0] S1 = 32'h003F_4800;
   localparam logic [31:0] S2 = 32'h007E_9000;

   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic        wr_start_stb_i = 1'b0;
   logic        wr_done_stb_i = 1'b0;
   logic        rd_next_stb_i = 1'b0;
   logic [31:0] wr_addr_o;
   logic        wr_active_o;
   logic [31:0] rd_addr_o;
   logic        rd_frame_valid_o;
   logic        rd_new_frame_o;
   logic        rd_repeat_o;
   logic [15:0] dropped_cnt_o;
   logic [15:0] repeat_cnt_o;

   int n_cmp = 0;
   int n_bad = 0;

   frame_slot_sched dut (
      .clk_i            (clk_i),
      .rst_n_i          (rst_n_i),
      .wr_start_stb_i   (wr_start_stb_i),
      .wr_done_stb_i    (wr_done_stb_i),
      .wr_addr_o        (wr_addr_o),
      .wr_active_o      (wr_active_o),
      .rd_next_stb_i    (rd_next_stb_i),
      .rd_addr_o        (rd_addr_o),
      .rd_frame_valid_o (rd_frame_valid_o),
      .rd_new_frame_o   (rd_new_frame_o),
      .rd_repeat_o      (rd_repeat_o),
      .dropped_cnt_o    (dropped_cnt_o),
      .repeat_cnt_o     (repeat_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        done;
      logic        rd;
      logic        start;
      logic [31:0] wr_addr;
      logic        wr_active;
      logic [31:0] rd_addr;
      logic        rd_valid;
      logic        rd_new;
      logic        rd_rep;
      logic [15:0] drop;
      logic [15:0] rep;
   } vec_t;

   vec_t vecs [19];

   task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
      end
   endtask

   task automatic check_all(input int idx, input vec_t v);
      check("wr_addr",   idx, wr_addr_o,        v.wr_addr);
      check("wr_active", idx, 32'(wr_active_o), 32'(v.wr_active));
      check("rd_addr",   idx, rd_addr_o,        v.rd_addr);
      check("rd_valid",  idx, 32'(rd_frame_valid_o), 32'(v.rd_valid));
      check("rd_new",    idx, 32'(rd_new_frame_o),   32'(v.rd_new));
      check("rd_repeat", idx, 32'(rd_repeat_o),      32'(v.rd_rep));
      check("dropped",   idx, 32'(dropped_cnt_o),    32'(v.drop));
      check("repeats",   idx, 32'(repeat_cnt_o),     32'(v.rep));
   endtask

   // One strobe cycle: drive on the falling edge, sample 1 ns after the rising edge.
   task automatic step(input logic d, input logic r, input logic s);
      @(negedge clk_i);
      wr_done_stb_i  = d;
      rd_next_stb_i  = r;
      wr_start_stb_i = s;
      @(posedge clk_i);
      #1;
      wr_done_stb_i  = 1'b0;
      rd_next_stb_i  = 1'b0;
      wr_start_stb_i = 1'b0;
   endtask

   function automatic vec_t mk(input logic d, input logic r, input logic s,
                               input logic [31:0] wa, input logic wact,
                               input logic [31:0] ra, input logic rv,
                               input logic rn, input logic rr,
                               input logic [15:0] dc, input logic [15:0] rc);
      vec_t v;
      v.done = d; v.rd = r; v.start = s;
      v.wr_addr = wa; v.wr_active = wact; v.rd_addr = ra; v.rd_valid = rv;
      v.rd_new = rn; v.rd_rep = rr; v.drop = dc; v.rep = rc;
      return v;
   endfunction

   vec_t rst_v;

   initial begin
      //             d  r  s   wr_addr act rd_addr vld new rep drop rcnt
      vecs[0]  = mk(0, 1, 0,  S0, 0,  S0, 0, 0, 1, 0, 1); // repeat before any frame
      vecs[1]  = mk(0, 0, 1,  S0, 1,  S0, 0, 0, 0, 0, 1); // writer gets slot 0
      vecs[2]  = mk(1, 0, 0,  S0, 0,  S0, 0, 0, 0, 0, 1); // slot 0 published
      vecs[3]  = mk(0, 1, 0,  S0, 0,  S0, 1, 1, 0, 0, 1); // reader takes slot 0
      vecs[4]  = mk(0, 0, 1,  S1, 1,  S0, 1, 0, 0, 0, 1); // writer avoids reader: slot 1
      vecs[5]  = mk(1, 0, 0,  S1, 0,  S0, 1, 0, 0, 0, 1); // slot 1 newest
      vecs[6]  = mk(0, 0, 1,  S2, 1,  S0, 1, 0, 0, 0, 1); // avoid 0 and 1: slot 2
      vecs[7]  = mk(1, 0, 0,  S2, 0,  S0, 1, 0, 0, 1, 1); // slot 1 dropped unread
      vecs[8]  = mk(0, 0, 1,  S1, 1,  S0, 1, 0, 0, 1, 1); // avoid 0 and 2: slot 1
      vecs[9]  = mk(0, 1, 0,  S1, 1,  S2, 1, 1, 0, 1, 1); // reader takes slot 2
      vecs[10] = mk(1, 1, 0,  S1, 0,  S1, 1, 1, 0, 1, 1); // done+read bypass
      vecs[11] = mk(0, 0, 1,  S0, 1,  S1, 1, 0, 0, 1, 1); // slot 0 free again
      vecs[12] = mk(1, 1, 1,  S1, 1,  S0, 1, 1, 0, 1, 1); // all three at once
      vecs[13] = mk(0, 0, 1,  S1, 1,  S0, 1, 0, 0, 1, 1); // abort, slot 1 reselected
      vecs[14] = mk(1, 0, 0,  S1, 0,  S0, 1, 0, 0, 1, 1); // slot 1 newest
      vecs[15] = mk(1, 0, 0,  S1, 0,  S0, 1, 0, 0, 1, 1); // done while idle ignored
      vecs[16] = mk(0, 0, 1,  S2, 1,  S0, 1, 0, 0, 1, 1); // avoid 0 and 1: slot 2
      vecs[17] = mk(0, 1, 0,  S2, 1,  S1, 1, 1, 0, 1, 1); // reader takes slot 1
      vecs[18] = mk(0, 1, 0,  S2, 1,  S1, 1, 0, 1, 1, 2); // nothing new: repeat

      rst_v = mk(0, 0, 0, S0, 0, S0, 0, 0, 0, 0, 0);

      // Reset state
      repeat (3) @(posedge clk_i);
      #1;
      check_all(-1, rst_v);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      @(posedge clk_i);
      #1;
      check_all(-2, rst_v);

      for (int i = 0; i < 19; i++) begin
         step(vecs[i].done, vecs[i].rd, vecs[i].start);
         $display("step %0d d=%0b r=%0b s=%0b wr=0x%0h act=%0b rd=0x%0h vld=%0b new=%0b rep=%0b drop=%0d rcnt=%0d",
                  i, vecs[i].done, vecs[i].rd, vecs[i].start, wr_addr_o, wr_active_o,
                  rd_addr_o, rd_frame_valid_o, rd_new_frame_o, rd_repeat_o,
                  dropped_cnt_o, repeat_cnt_o);
         check_all(i, vecs[i]);
      end

      // Idle cycle: pulses drop, everything else holds
      step(0, 0, 0);
      check_all(19, mk(0, 0, 0, S2, 1, S1, 1, 0, 0, 1, 2));

      // Asynchronous reset mid-frame, asserted away from any clock edge
      @(negedge clk_i);
      #2;
      rst_n_i = 1'b0;
      #1;
      $display("async reset: wr=0x%0h act=%0b rd=0x%0h vld=%0b drop=%0d rcnt=%0d",
               wr_addr_o, wr_active_o, rd_addr_o, rd_frame_valid_o, dropped_cnt_o, repeat_cnt_o);
      check_all(20, rst_v);
      @(posedge clk_i);
      #1;
      rst_n_i = 1'b1;
      check_all(21, rst_v);

      // After reset the old newest frame is forgotten: reader repeats, writer gets slot 0
      step(0, 1, 0);
      check_all(22, mk(0, 1, 0, S0, 0, S0, 0, 0, 1, 0, 1));
      step(0, 0, 1);
      check_all(23, mk(0, 0, 1, S0, 1, S0, 0, 0, 0, 0, 1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/frame_slot_sched.md
Name: frame_slot_sched

Overview:
- Frame-slot scheduler for the multi-buffer frame store in external memory.
- Decides which frame slot the write side fills and which slot the read side scans out. Hands each side a base address.
- Guarantees that the writer never touches the slot being read, or the newest completed unread slot (no tearing, triple buffering).
- Sits between the video write DMA controller and the frame read controller. Replaces their ad-hoc frame counting.

Parameters:
START_ADDR, 0, byte address of slot 0
FRAMES_AMOUNT, 3, number of frame slots; must be >= 3, elaboration error otherwise
BYTES_PER_FRAME, 4147200, slot stride in bytes (1920x1080x2)
ADDR_WIDTH, 32, address width
CNT_WIDTH, 16, width of statistics counters

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset, asynchronous, active-low
wr_start_stb_i  in  1  writer starts a frame; requests a slot
wr_done_stb_i  in  1  writer finished the current frame
wr_addr_o  out  ADDR_WIDTH  base address of the slot being written
wr_active_o  out  1  writer owns a slot
rd_next_stb_i  in  1  reader finished a frame; requests the next one
rd_addr_o  out  ADDR_WIDTH  base address of the slot being read
rd_frame_valid_o  out  1  rd_addr_o points at a completed frame
rd_new_frame_o  out  1  one-cycle pulse: reader switched to a fresh frame
rd_repeat_o  out  1  one-cycle pulse: no fresh frame, reader repeats the current slot
dropped_cnt_o  out  CNT_WIDTH  completed frames overwritten unread, saturating
repeat_cnt_o  out  CNT_WIDTH  rd_repeat_o pulses, saturating

Behaviour:
- Reset (async assert, sync release) values:
  - wr_slot = 0, rd_slot = 0, newest_slot = 0
  - newest_valid = 0, wr_active_o = 0, rd_frame_valid_o = 0
  - wr_addr_o = rd_addr_o = START_ADDR
  - pulses = 0, counters = 0
- Slot index width: $clog2(FRAMES_AMOUNT). Base address = START_ADDR + slot*BYTES_PER_FRAME, computed in ADDR_WIDTH and registered with the slot. Outputs change exactly 1 cycle after the causing strobe.
- Same-cycle events resolve in fixed order: done, then read, then write.
- Step 1, wr_done_stb_i:
  - Ignored unless wr_active_o = 1.
  - If newest_valid = 1 and newest_slot is not rd_slot, increment dropped_cnt_o.
  - newest_slot <= wr_slot; newest_valid <= 1; wr_active_o <= 0.
- Step 2, rd_next_stb_i, evaluated on the post-step-1 newest state (bypass, so a same-cycle done is consumed):
  - If newest_valid = 1: rd_slot <= newest_slot, newest_valid <= 0, rd_frame_valid_o <= 1, rd_new_frame_o pulses.
  - Otherwise: rd_slot is unchanged, rd_repeat_o pulses, repeat_cnt_o increments.
- Step 3, wr_start_stb_i:
  - Pick the lowest index i that satisfies both:
    - not (rd_frame_valid_next and i == rd_slot_next);
    - not (newest_valid_next and i == newest_slot_next).
  - wr_slot <= i; wr_active_o <= 1.
  - A start while already active aborts the current frame. The aborted slot is not published and may be reselected.
  - FRAMES_AMOUNT >= 3 guarantees a legal slot always exists.
- wr_done_stb_i and wr_start_stb_i in the same cycle: publish first, then select excluding the new newest slot.
- Counters saturate at all-ones and never wrap.
- rd_addr_o is stable except one cycle after rd_next_stb_i. wr_addr_o is stable except one cycle after wr_start_stb_i.
- Reset mid-frame returns all state to reset values immediately. In-flight frames are forgotten.

Test Plan:
- Reset, then rd_next_stb_i:
  - rd_repeat_o = 1, rd_frame_valid_o = 0, rd_addr_o = 0x0, repeat_cnt_o = 1.
  - Then wr_start_stb_i: wr_addr_o = 0x0, wr_active_o = 1.
- wr_done (slot 0), then rd_next:
  - rd_addr_o = 0x0, rd_new_frame_o = 1, rd_frame_valid_o = 1.
  - Then wr_start: wr_addr_o = 0x3F4800 (slot 1).
- Writer outruns reader (reader on slot 0):
  - Slot 1 done, then wr_start: wr_addr_o = 0x7E9000 (slot 2).
  - Slot 2 done: dropped_cnt_o = 1.
  - wr_start: wr_addr_o = 0x3F4800.
  - rd_next: rd_addr_o = 0x7E9000.
- wr_done (slot 1) and rd_next in the same cycle, reader on slot 0:
  - rd_addr_o = 0x3F4800, rd_new_frame_o = 1, dropped_cnt_o unchanged.
  - Next wr_start selects slot 0.
- wr_done, rd_next and wr_start all in the same cycle:
  - Reader takes the finished slot.
  - Writer gets the lowest slot that is neither the reader's slot nor the newest; no slot is shared.
- Assert rst_n_i low for 1 cycle while wr_active_o = 1 and rd_frame_valid_o = 1:
  - All outputs return to reset values within the same cycle, asynchronously.
  - Counters read 0.
